// File: rtl/y_sig_pkg.sv
// y_sig_pkg: shared types and default constants for the y signature checker.
//   state_t        : checker FSM states (IDLE, CAPTURE, DONE)
//   SIG_WIDTH_DEF  : default MISR / signature width
//   POLY_DEF       : default MISR feedback polynomial
//   SEED_DEF       : default signature value loaded on start
//   CNT_WIDTH_DEF  : default sample counter width
package y_sig_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam int          SIG_WIDTH_DEF = 32;
  localparam logic [31:0] POLY_DEF      = 32'h04C1_1DB7;
  localparam logic [31:0] SEED_DEF      = 32'hFFFF_FFFF;
  localparam int          CNT_WIDTH_DEF = 16;

endpackage

// File: rtl/y_sig_misr_step.sv
// y_sig_misr_step: combinational fold of a wide sample into SIG_WIDTH bits,
// followed by one MISR step.
//   sig      in  SIG_WIDTH  current signature
//   y        in  Y_WIDTH    sample vector
//   sig_next out SIG_WIDTH  signature after compacting y
module y_sig_misr_step
  import y_sig_pkg::*;
#(
  parameter int                   Y_WIDTH   = 421,
  parameter int                   SIG_WIDTH = SIG_WIDTH_DEF,
  parameter logic [SIG_WIDTH-1:0] POLY      = POLY_DEF[SIG_WIDTH-1:0]
) (
  input  logic [SIG_WIDTH-1:0] sig,
  input  logic [Y_WIDTH-1:0]   y,
  output logic [SIG_WIDTH-1:0] sig_next
);

  localparam int N_CHUNKS = (Y_WIDTH + SIG_WIDTH - 1) / SIG_WIDTH;

  logic [N_CHUNKS*SIG_WIDTH-1:0] y_ext;
  logic [SIG_WIDTH-1:0]          fold;

  // Zero-extend so the top chunk is padded with zeros, then XOR all chunks.
  always_comb begin
    y_ext = '0;
    y_ext[Y_WIDTH-1:0] = y;
    fold = '0;
    for (int i = 0; i < N_CHUNKS; i++) begin
      fold = fold ^ y_ext[i*SIG_WIDTH +: SIG_WIDTH];
    end
  end

  assign sig_next = {sig[SIG_WIDTH-2:0], 1'b0}
                  ^ (sig[SIG_WIDTH-1] ? POLY : '0)
                  ^ fold;

endmodule

// File: rtl/y_signature_checker.sv
// y_signature_checker: samples a DUT output vector over a programmed number of
// valid cycles, compacts it into a MISR signature and compares the result with
// a golden signature.
//   clk, rst           clock / asynchronous active-high reset
//   start              begin a run (only honoured in IDLE)
//   num_cycles         valid samples to compact, latched on start
//   expected_sig       golden signature, latched on start
//   y_in, y_valid      sample vector and its qualifier
//   busy               high in CAPTURE and DONE
//   done               one-cycle pulse in DONE
//   pass               result of the last completed run
//   signature          current MISR value
// Optional macro Y_SIG_FIRST_MISMATCH_EN adds y_ref, mismatch_seen and
// first_mismatch_idx; pass then also requires that no sample differed from y_ref.
//
// state   | meaning
// IDLE    | waiting for start
// CAPTURE | compacting valid samples until the count is reached
// DONE    | one-cycle result cycle, done=1, pass valid
module y_signature_checker
  import y_sig_pkg::*;
#(
  parameter int                   Y_WIDTH   = 421,
  parameter int                   SIG_WIDTH = SIG_WIDTH_DEF,
  parameter logic [SIG_WIDTH-1:0] POLY      = POLY_DEF[SIG_WIDTH-1:0],
  parameter logic [SIG_WIDTH-1:0] SEED      = SEED_DEF[SIG_WIDTH-1:0],
  parameter int                   CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] num_cycles,
  input  logic [SIG_WIDTH-1:0] expected_sig,
  input  logic [Y_WIDTH-1:0]   y_in,
  input  logic                 y_valid,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [SIG_WIDTH-1:0] signature
`ifdef Y_SIG_FIRST_MISMATCH_EN
  ,
  input  logic [Y_WIDTH-1:0]   y_ref,
  output logic                 mismatch_seen,
  output logic [CNT_WIDTH-1:0] first_mismatch_idx
`endif
);

  state_t               state;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic [CNT_WIDTH-1:0] num_lat;
  logic [SIG_WIDTH-1:0] exp_lat;
  logic [SIG_WIDTH-1:0] sig_next;
  logic                 mis_after;

  y_sig_misr_step #(
    .Y_WIDTH   (Y_WIDTH),
    .SIG_WIDTH (SIG_WIDTH),
    .POLY      (POLY)
  ) u_step (
    .sig      (signature),
    .y        (y_in),
    .sig_next (sig_next)
  );

  assign cnt_inc = cnt + CNT_WIDTH'(1);

`ifdef Y_SIG_FIRST_MISMATCH_EN
  logic mis_now;
  assign mis_now   = (y_in != y_ref);
  assign mis_after = mismatch_seen | mis_now;
`else
  assign mis_after = 1'b0;
`endif

  // pass is computed on the edge entering DONE so it is already valid while
  // done is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      signature <= SEED;
      cnt       <= '0;
      num_lat   <= '0;
      exp_lat   <= '0;
`ifdef Y_SIG_FIRST_MISMATCH_EN
      mismatch_seen      <= 1'b0;
      first_mismatch_idx <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            signature <= SEED;
            cnt       <= '0;
            num_lat   <= num_cycles;
            exp_lat   <= expected_sig;
            busy      <= 1'b1;
`ifdef Y_SIG_FIRST_MISMATCH_EN
            mismatch_seen      <= 1'b0;
            first_mismatch_idx <= '0;
`endif
            if (num_cycles == '0) begin
              state <= DONE;
              done  <= 1'b1;
              pass  <= (SEED == expected_sig);
            end else begin
              state <= CAPTURE;
              pass  <= 1'b0;
            end
          end
        end
        CAPTURE: begin
          if (y_valid) begin
            signature <= sig_next;
            cnt       <= cnt_inc;
`ifdef Y_SIG_FIRST_MISMATCH_EN
            if (mis_now && !mismatch_seen) begin
              mismatch_seen      <= 1'b1;
              first_mismatch_idx <= cnt;
            end
`endif
            if (cnt_inc == num_lat) begin
              state <= DONE;
              done  <= 1'b1;
              pass  <= (sig_next == exp_lat) && !mis_after;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_y_signature_checker.sv
// Directed bench for y_signature_checker with an 8-bit configuration
// (POLY 8'h1D, SEED 8'hFF) plus a 12-bit-input instance with SEED 0 for the fold.
module tb_y_signature_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start = 1'b0;
  logic [15:0] num_cycles = '0;
  logic [7:0]  expected_sig = '0;
  logic [7:0]  y_in = '0;
  logic        y_valid = 1'b0;
  logic        busy, done, pass;
  logic [7:0]  signature;

  logic        f_start = 1'b0;
  logic [15:0] f_num = '0;
  logic [7:0]  f_exp = '0;
  logic [11:0] f_y = '0;
  logic        f_valid = 1'b0;
  logic        f_busy, f_done, f_pass;
  logic [7:0]  f_sig;

  int n_vec  = 0;
  int n_miss = 0;

`ifdef Y_SIG_FIRST_MISMATCH_EN
  logic [7:0]  ref_flip = '0;
  logic [7:0]  y_ref;
  logic        mismatch_seen, f_mis;
  logic [15:0] first_mismatch_idx, f_idx;
  assign y_ref = y_in ^ ref_flip;
`endif

  always #5 clk = ~clk;

  y_signature_checker #(
    .Y_WIDTH(8), .SIG_WIDTH(8), .POLY(8'h1D), .SEED(8'hFF), .CNT_WIDTH(16)
  ) u_dut (
    .clk(clk), .rst(rst), .start(start), .num_cycles(num_cycles),
    .expected_sig(expected_sig), .y_in(y_in), .y_valid(y_valid),
    .busy(busy), .done(done), .pass(pass), .signature(signature)
`ifdef Y_SIG_FIRST_MISMATCH_EN
    , .y_ref(y_ref), .mismatch_seen(mismatch_seen),
    .first_mismatch_idx(first_mismatch_idx)
`endif
  );

  y_signature_checker #(
    .Y_WIDTH(12), .SIG_WIDTH(8), .POLY(8'h1D), .SEED(8'h00), .CNT_WIDTH(16)
  ) u_fold (
    .clk(clk), .rst(rst), .start(f_start), .num_cycles(f_num),
    .expected_sig(f_exp), .y_in(f_y), .y_valid(f_valid),
    .busy(f_busy), .done(f_done), .pass(f_pass), .signature(f_sig)
`ifdef Y_SIG_FIRST_MISMATCH_EN
    , .y_ref(f_y), .mismatch_seen(f_mis), .first_mismatch_idx(f_idx)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_start(input logic [15:0] n, input logic [7:0] e);
    start = 1'b1;
    num_cycles = n;
    expected_sig = e;
    tick();
    start = 1'b0;
  endtask

  task automatic sample(input logic [7:0] y);
    y_in = y;
    y_valid = 1'b1;
    tick();
    y_valid = 1'b0;
  endtask

  initial begin
    // reset state
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_sig", 32'(signature), 32'hFF);
    rst = 1'b0;
    tick();

    // single zero sample: FF -> E3
    run_start(16'd1, 8'hE3);
    chk("s1_busy", 32'(busy), 32'd1);
    chk("s1_done_early", 32'(done), 32'd0);
    sample(8'h00);
    chk("s1_sig", 32'(signature), 32'hE3);
    chk("s1_done", 32'(done), 32'd1);
    chk("s1_pass", 32'(pass), 32'd1);
    tick();
    chk("s1_done_clr", 32'(done), 32'd0);
    chk("s1_busy_clr", 32'(busy), 32'd0);
    chk("s1_pass_hold", 32'(pass), 32'd1);

    // zero-length run, y_valid in start cycle ignored
    y_in = 8'h55;
    y_valid = 1'b1;
    run_start(16'd0, 8'hFF);
    y_valid = 1'b0;
    chk("z_done", 32'(done), 32'd1);
    chk("z_sig", 32'(signature), 32'hFF);
    chk("z_pass", 32'(pass), 32'd1);
    tick();
    chk("z_done_clr", 32'(done), 32'd0);
    run_start(16'd0, 8'h00);
    chk("z0_done", 32'(done), 32'd1);
    chk("z0_pass", 32'(pass), 32'd0);
    tick();

    // gapped samples: FF -> E3 -> DB
    run_start(16'd2, 8'hDB);
    sample(8'h00);
    chk("g_sig1", 32'(signature), 32'hE3);
    chk("g_done1", 32'(done), 32'd0);
    for (int i = 0; i < 3; i++) tick();
    chk("g_gap_sig", 32'(signature), 32'hE3);
    chk("g_gap_busy", 32'(busy), 32'd1);
    chk("g_gap_done", 32'(done), 32'd0);
    sample(8'h00);
    chk("g_sig2", 32'(signature), 32'hDB);
    chk("g_done2", 32'(done), 32'd1);
    chk("g_pass", 32'(pass), 32'd1);
    tick();

    // nonzero data, wrong golden: FF -> E3^5A = B9
    run_start(16'd1, 8'h00);
    sample(8'h5A);
    chk("d_sig", 32'(signature), 32'hB9);
    chk("d_done", 32'(done), 32'd1);
    chk("d_pass", 32'(pass), 32'd0);
    tick();

    // start during CAPTURE ignored: FF -> E2 -> DB -> A8
    run_start(16'd3, 8'hA8);
    sample(8'h01);
    chk("b_sig1", 32'(signature), 32'hE2);
    start = 1'b1;
    num_cycles = 16'd0;
    expected_sig = 8'h00;
    sample(8'h02);
    start = 1'b0;
    chk("b_sig2", 32'(signature), 32'hDB);
    chk("b_done2", 32'(done), 32'd0);
    sample(8'h03);
    chk("b_sig3", 32'(signature), 32'hA8);
    chk("b_done3", 32'(done), 32'd1);
    chk("b_pass", 32'(pass), 32'd1);
    tick();

    // fold: 12'hF0F -> 0F^0F = 0; 12'h123 -> 23^01 = 22 (SEED 0)
    f_start = 1'b1; f_num = 16'd1; f_exp = 8'h00;
    tick();
    f_start = 1'b0; f_y = 12'hF0F; f_valid = 1'b1;
    tick();
    f_valid = 1'b0;
    chk("f_sig0", 32'(f_sig), 32'h00);
    chk("f_done0", 32'(f_done), 32'd1);
    chk("f_pass0", 32'(f_pass), 32'd1);
    tick();
    f_start = 1'b1; f_num = 16'd1; f_exp = 8'h22;
    tick();
    f_start = 1'b0; f_y = 12'h123; f_valid = 1'b1;
    tick();
    f_valid = 1'b0;
    chk("f_sig1", 32'(f_sig), 32'h22);
    chk("f_pass1", 32'(f_pass), 32'd1);
    tick();

`ifdef Y_SIG_FIRST_MISMATCH_EN
    // 4 zero samples, ref differs on samples 2 and 3: FF->E3->DB->AB->4B
    run_start(16'd4, 8'h4B);
    sample(8'h00);
    sample(8'h00);
    ref_flip = 8'h10;
    sample(8'h00);
    sample(8'h00);
    ref_flip = 8'h00;
    chk("m_sig", 32'(signature), 32'h4B);
    chk("m_seen", 32'(mismatch_seen), 32'd1);
    chk("m_idx", 32'(first_mismatch_idx), 32'd2);
    chk("m_pass", 32'(pass), 32'd0);
    tick();
    chk("m_seen_hold", 32'(mismatch_seen), 32'd1);
`endif

    // reset mid-run: immediate abort, no done pulse
    run_start(16'd5, 8'h00);
    sample(8'h00);
    chk("r_sig_pre", 32'(signature), 32'hE3);
    rst = 1'b1;
    #1;
    chk("r_busy", 32'(busy), 32'd0);
    chk("r_sig", 32'(signature), 32'hFF);
    chk("r_done", 32'(done), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("r_done_after", 32'(done), 32'd0);
    chk("r_busy_after", 32'(busy), 32'd0);
    chk("r_pass_after", 32'(pass), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
